pixel_payload_scheduler: RTL and testbench
==========================================

// Module: pixel_payload_scheduler
// PURPOSE
//  Shares the single MIPI pixel-payload generator between NREQ requesters (miner result sources).
//  Round-robin arbitrates pending requests and latches the winner's payload into gen_data.
//  Arms the generator for the next frame start, tracks gen_busy through one framed transfer,
//  then acknowledges the requester. A frame watchdog recovers from a stalled generator.
//  Sits between the requesters and the generator's data/data_available/busy pins, on tx_pixel_clk.
// PARAMETERS
//  DLEN            43  payload length in bytes (matches generator DLEN)
//  NREQ            2   number of requesters, >=2
//  TIMEOUT_FRAMES  4   frame starts tolerated in ARM/SEND before abort, >=1
// PORTS
//  tx_pixel_clk        in   1            pixel clock, all logic on posedge
//  rst                 in   1            synchronous, active-high reset
//  x                   in   10           current pixel column from TX timing
//  y                   in   10           current line from TX timing
//  req                 in   NREQ         per-requester transfer request, level
//  payload_i           in   NREQ*DLEN*8  requester i payload at [i*DLEN*8 +: DLEN*8]
//  ack                 out  NREQ         one-cycle pulse: requester i payload fully sent
//  grant               out  NREQ         one-hot, current owner of the generator
//  gen_data            out  DLEN*8       latched payload to generator
//  gen_data_available  out  1            high in ARM and SEND
//  gen_busy            in   1            generator busy flag
//  sent_count          out  16           completed transfers, wraps 0xFFFF->0
//  err_timeout         out  1            one-cycle pulse on watchdog abort
//  err_sticky          out  1            set on any abort, cleared only by rst
// BEHAVIOUR
//  Reset: state=IDLE; ack, grant, gen_data, gen_data_available, sent_count, err_* = 0;
//   rr_ptr=NREQ-1 (so index 0 wins first); busy_seen=0; frame_cnt=0; sof_prev=0.
//  sof: registered edge of (x==0 && y==0): sof = cond && !sof_prev; sof_prev <= cond every cycle.
//  States: IDLE -> ARM -> SEND -> DONE -> IDLE; ARM/SEND -> IDLE on timeout.
//  IDLE: if |req, winner = first set bit searching rr_ptr+1 .. rr_ptr+NREQ (mod NREQ).
//   Next edge: grant=onehot(winner), gen_data=payload_i slice, state=ARM. Latency req->grant 1 cycle.
//   No req: stay, grant=0.
//  ARM: gen_data_available=1. On sof: state=SEND, busy_seen=0, frame_cnt=1.
//  SEND: busy_seen<=1 when gen_busy=1. Edge with busy_seen && !gen_busy -> DONE.
//   Each further sof increments frame_cnt.
//  DONE (one cycle): ack[owner]=1, grant=0, gen_data_available=0, sent_count+1,
//   rr_ptr=owner; next state IDLE. gen_data keeps last value.
//  Watchdog: in ARM or SEND, count sof pulses in frame_cnt (ARM counts too, from 0).
//   When the count reaches TIMEOUT_FRAMES and no completion occurs on that edge:
//   err_timeout pulse, err_sticky=1, grant=0, data_available=0, no ack, no sent_count change,
//   rr_ptr=owner, state=IDLE.
//  Completion and timeout on the same edge: completion wins.
//  gen_data and grant stay stable from the IDLE latch until DONE or abort.
//  req is sampled only in IDLE. Dropping req after grant has no effect: the transfer completes
//   and ack still pulses. A req still high after its ack is re-eligible, but other pending
//   requesters win first (rotation).
//  Reset mid-transfer returns every output to its reset value on the next edge; the generator's
//   frame is not tracked further.
//  No combinational path from inputs to outputs; all outputs are registered.
// TESTING
//  T1 single: req=01, payload0=0x11..; sof, busy 1 for 8 cycles then 0 ->
//   grant=01 next cycle, data_available=1, ack=01 for exactly 1 cycle after busy low, sent_count=1.
//  T2 rr: req=11 held, busy ack each frame -> grant order 01,10,01,10; sent_count=4 after 4 frames.
//  T3 timeout: req=01, gen_busy stuck 0 -> err_timeout pulse on 4th sof after ARM entry,
//   err_sticky=1, ack never asserted, grant=0, sent_count unchanged.
//  T4 withdraw: req=10 for 1 cycle only, then 0 -> transfer still runs, ack=10 pulses once,
//   gen_data equals payload1 throughout.
//  T5 reset mid-SEND: assert rst while gen_busy=1 -> next cycle grant=0, data_available=0,
//   sent_count=0, err_sticky=0, state IDLE.
//  T6 wrap: preload via 65535 transfers (or force) -> one more completion gives sent_count=0.

Source files
------------

// File: rtl/pixel_payload_scheduler_if.sv
// rtl/pixel_payload_scheduler_if.sv - requester/generator handshake bundle for the payload scheduler
// Ports (signals):
//   req, payload_i        requester side, into the scheduler
//   ack, grant            requester side, out of the scheduler
//   gen_data, gen_data_available  generator side, out of the scheduler
//   gen_busy              generator side, into the scheduler
// Modports: master = scheduler, slave = requesters/generator environment.
interface pixel_payload_scheduler_if #(
    parameter int DLEN = 43,
    parameter int NREQ = 2
);
    logic [NREQ-1:0]        req;
    logic [NREQ*DLEN*8-1:0] payload_i;
    logic [NREQ-1:0]        ack;
    logic [NREQ-1:0]        grant;
    logic [DLEN*8-1:0]      gen_data;
    logic                   gen_data_available;
    logic                   gen_busy;

    modport master (
        input  req, payload_i, gen_busy,
        output ack, grant, gen_data, gen_data_available
    );

    modport slave (
        output req, payload_i, gen_busy,
        input  ack, grant, gen_data, gen_data_available
    );
endinterface

// File: rtl/pixel_payload_scheduler.sv
// rtl/pixel_payload_scheduler.sv - round-robin sharing of one pixel-payload generator among NREQ requesters
// Ports:
//   tx_pixel_clk  pixel clock, all logic on posedge
//   rst           synchronous active-high reset
//   x, y          current pixel column/line, (0,0) marks frame start
//   bus           requester/generator bundle (master modport)
//   sent_count    completed transfers, wraps
//   err_timeout   one-cycle pulse on watchdog abort
//   err_sticky    set on any abort until reset
module pixel_payload_scheduler #(
    parameter int DLEN           = 43,
    parameter int NREQ           = 2,
    parameter int TIMEOUT_FRAMES = 4
) (
    input  logic                      tx_pixel_clk,
    input  logic                      rst,
    input  logic [9:0]                x,
    input  logic [9:0]                y,
    pixel_payload_scheduler_if.master bus,
    output logic [15:0]               sent_count,
    output logic                      err_timeout,
    output logic                      err_sticky
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int FW = $clog2(TIMEOUT_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, ARM, SEND, DONE} state_t;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   cand;
    logic            found;
    logic            busy_seen;
    logic            sof_prev;
    logic            sof_cond;
    logic            sof;
    logic            frames_up;
    logic [FW-1:0]   frame_cnt;
    logic [DLEN*8-1:0] slice [NREQ];

    assign sof_cond = (x == 10'd0) && (y == 10'd0);
    assign sof      = sof_cond && !sof_prev;

    // The frame start about to be counted would bring the watchdog to its limit.
    assign frames_up = sof && ((frame_cnt + FW'(1)) >= FW'(TIMEOUT_FRAMES));

    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign slice[g] = bus.payload_i[g*DLEN*8 +: DLEN*8];
    end

    // Search starts just after the last owner, so a requester that was just
    // served goes to the back of the line.
    always_comb begin
        found  = 1'b0;
        winner = rr_ptr;
        cand   = rr_ptr;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(rr_ptr) + k) % NREQ);
            if (!found && bus.req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_ff @(posedge tx_pixel_clk) begin
        if (rst) begin
            state                  <= IDLE;
            rr_ptr                 <= IW'(NREQ - 1);
            owner                  <= '0;
            busy_seen              <= 1'b0;
            frame_cnt              <= '0;
            sof_prev               <= 1'b0;
            bus.ack                <= '0;
            bus.grant              <= '0;
            bus.gen_data           <= '0;
            bus.gen_data_available <= 1'b0;
            sent_count             <= '0;
            err_timeout            <= 1'b0;
            err_sticky             <= 1'b0;
        end else begin
            sof_prev    <= sof_cond;
            bus.ack     <= '0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        owner                  <= winner;
                        bus.grant              <= '0;
                        bus.grant[winner]      <= 1'b1;
                        bus.gen_data           <= slice[winner];
                        bus.gen_data_available <= 1'b1;
                        frame_cnt              <= '0;
                        state                  <= ARM;
                    end
                end
                ARM: begin
                    if (frames_up) begin
                        err_timeout            <= 1'b1;
                        err_sticky             <= 1'b1;
                        bus.grant              <= '0;
                        bus.gen_data_available <= 1'b0;
                        rr_ptr                 <= owner;
                        state                  <= IDLE;
                    end else if (sof) begin
                        busy_seen <= 1'b0;
                        frame_cnt <= FW'(1);
                        state     <= SEND;
                    end
                end
                SEND: begin
                    // Completion is checked first so it wins over a same-edge timeout.
                    if (busy_seen && !bus.gen_busy) begin
                        bus.ack[owner]         <= 1'b1;
                        bus.grant              <= '0;
                        bus.gen_data_available <= 1'b0;
                        sent_count             <= sent_count + 16'd1;
                        rr_ptr                 <= owner;
                        state                  <= DONE;
                    end else if (frames_up) begin
                        err_timeout            <= 1'b1;
                        err_sticky             <= 1'b1;
                        bus.grant              <= '0;
                        bus.gen_data_available <= 1'b0;
                        rr_ptr                 <= owner;
                        state                  <= IDLE;
                    end else begin
                        if (sof) begin
                            frame_cnt <= frame_cnt + FW'(1);
                        end
                        if (bus.gen_busy) begin
                            busy_seen <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pixel_payload_scheduler.sv
// tb/tb_pixel_payload_scheduler.sv - self-checking bench for pixel_payload_scheduler
module tb_pixel_payload_scheduler;
    localparam int DLEN    = 43;
    localparam int NREQ    = 2;
    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] sent_count;
    logic        err_timeout;
    logic        err_sticky;

    pixel_payload_scheduler_if #(.DLEN(DLEN), .NREQ(NREQ)) bus ();

    pixel_payload_scheduler #(.DLEN(DLEN), .NREQ(NREQ), .TIMEOUT_FRAMES(TIMEOUT)) dut (
        .tx_pixel_clk (clk),
        .rst          (rst),
        .x            (x),
        .y            (y),
        .bus          (bus),
        .sent_count   (sent_count),
        .err_timeout  (err_timeout),
        .err_sticky   (err_sticky)
    );

    always #5 clk = ~clk;

    logic [DLEN*8-1:0] pay0 = {DLEN{8'h11}};
    logic [DLEN*8-1:0] pay1 = {DLEN{8'hA5}};

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    bit skip_cmp = 1'b0;
    int ack0_n = 0;
    int ack1_n = 0;

    // Model state: what the scheduler must be doing, in transfer terms.
    logic [1:0]        e_grant = '0;
    logic [1:0]        e_ack = '0;
    logic [DLEN*8-1:0] e_gdata = '0;
    logic              e_avail = 1'b0;
    logic [15:0]       e_cnt = '0;
    logic              e_to = 1'b0;
    logic              e_sticky = 1'b0;
    bit m_prev, m_cond, m_sof, m_active, m_done, m_sending, m_saw, m_fin;
    int m_frames, m_owner, last_owner;

    task automatic chk(input string name, input logic [DLEN*8-1:0] act, input logic [DLEN*8-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame();
        x = 10'd0;
        y = 10'd0;
        tick(1);
        x = 10'd5;
        y = 10'd3;
    endtask

    function automatic bit reqbit(input int i);
        return (i == 0) ? bus.req[0] : bus.req[1];
    endfunction

    always @(posedge clk) begin
        m_cond = (x == 10'd0) && (y == 10'd0);
        m_sof  = m_cond && !m_prev;
        m_prev = m_cond;
        e_ack  = '0;
        e_to   = 1'b0;
        if (rst) begin
            m_prev = 0; m_active = 0; m_done = 0; m_sending = 0; m_saw = 0;
            m_frames = 0; last_owner = NREQ - 1;
            e_grant = '0; e_gdata = '0; e_avail = 0; e_cnt = '0; e_sticky = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_active) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (!m_active && reqbit((last_owner + k) % NREQ)) begin
                    m_active  = 1;
                    m_owner   = (last_owner + k) % NREQ;
                    m_sending = 0;
                    m_frames  = 0;
                    e_grant   = (m_owner == 0) ? 2'b01 : 2'b10;
                    e_gdata   = (m_owner == 0) ? pay0 : pay1;
                    e_avail   = 1;
                end
            end
        end else begin
            m_fin = m_sending && m_saw && !bus.gen_busy;
            if (m_sof) m_frames++;
            if (m_fin) begin
                e_ack = e_grant; e_grant = '0; e_avail = 0; e_cnt = e_cnt + 16'd1;
                last_owner = m_owner; m_active = 0; m_done = 1;
            end else if (m_frames >= TIMEOUT) begin
                e_to = 1; e_sticky = 1; e_grant = '0; e_avail = 0;
                last_owner = m_owner; m_active = 0;
            end else if (!m_sending) begin
                if (m_sof) begin
                    m_sending = 1;
                    m_saw = 0;
                end
            end else if (bus.gen_busy) begin
                m_saw = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en && !skip_cmp) begin
            chk("grant", bus.grant, e_grant);
            chk("ack", bus.ack, e_ack);
            chk("gen_data", bus.gen_data, e_gdata);
            chk("data_available", bus.gen_data_available, e_avail);
            chk("sent_count", sent_count, e_cnt);
            chk("err_timeout", err_timeout, e_to);
            chk("err_sticky", err_sticky, e_sticky);
        end
        if (bus.ack[0] === 1'b1) ack0_n++;
        if (bus.ack[1] === 1'b1) ack1_n++;
    end

    initial begin
        rst = 1'b1;
        x = 10'd5;
        y = 10'd3;
        bus.req = '0;
        bus.gen_busy = 1'b0;
        bus.payload_i = {pay1, pay0};
        tick(2);
        cmp_en = 1'b1;
        chk("reset_grant", bus.grant, 2'b00);
        chk("reset_sent_count", sent_count, 16'd0);
        rst = 1'b0;
        tick(1);

        // T1 single transfer
        ack0_n = 0;
        bus.req = 2'b01;
        tick(1);
        chk("t1_grant", bus.grant, 2'b01);
        chk("t1_avail", bus.gen_data_available, 1'b1);
        bus.req = 2'b00;
        frame();
        bus.gen_busy = 1'b1;
        tick(8);
        bus.gen_busy = 1'b0;
        tick(1);
        chk("t1_ack", bus.ack, 2'b01);
        tick(1);
        chk("t1_ack_drop", bus.ack, 2'b00);
        chk("t1_sent_count", sent_count, 16'd1);
        chk("t1_ack_pulses", ack0_n, 1);

        // T2 round-robin with both requesting
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        bus.req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            chk("t2_grant_order", bus.grant, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k == 3) bus.req = 2'b00;
            frame();
            bus.gen_busy = 1'b1;
            tick(2);
            bus.gen_busy = 1'b0;
            tick(1);
            tick(1);
        end
        chk("t2_sent_count", sent_count, 16'd4);

        // T3 watchdog with generator never going busy
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        ack0_n = 0;
        bus.req = 2'b01;
        tick(1);
        bus.req = 2'b00;
        for (int k = 0; k < TIMEOUT; k++) begin
            chk("t3_no_timeout_early", err_timeout, 1'b0);
            frame();
            tick(1);
        end
        tick(1);
        chk("t3_sticky", err_sticky, 1'b1);
        chk("t3_grant", bus.grant, 2'b00);
        chk("t3_sent_count", sent_count, 16'd0);
        chk("t3_no_ack", ack0_n, 0);

        // T4 request withdrawn after one cycle
        ack1_n = 0;
        bus.req = 2'b10;
        tick(1);
        bus.req = 2'b00;
        chk("t4_grant", bus.grant, 2'b10);
        chk("t4_data", bus.gen_data, pay1);
        frame();
        bus.gen_busy = 1'b1;
        tick(3);
        chk("t4_data_mid", bus.gen_data, pay1);
        bus.gen_busy = 1'b0;
        tick(1);
        chk("t4_ack", bus.ack, 2'b10);
        tick(2);
        chk("t4_ack_pulses", ack1_n, 1);
        chk("t4_sent_count", sent_count, 16'd1);

        // T5 reset while the generator is busy
        bus.req = 2'b01;
        tick(1);
        bus.req = 2'b00;
        frame();
        bus.gen_busy = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(1);
        chk("t5_grant", bus.grant, 2'b00);
        chk("t5_avail", bus.gen_data_available, 1'b0);
        chk("t5_sent_count", sent_count, 16'd0);
        chk("t5_sticky", err_sticky, 1'b0);
        rst = 1'b0;
        bus.gen_busy = 1'b0;
        tick(1);

        // T6 counter wrap from a preloaded 0xFFFF
        skip_cmp = 1'b1;
        force dut.sent_count = 16'hFFFF;
        tick(1);
        release dut.sent_count;
        e_cnt = 16'hFFFF;
        tick(1);
        chk("t6_preload", sent_count, 16'hFFFF);
        skip_cmp = 1'b0;
        bus.req = 2'b01;
        tick(1);
        bus.req = 2'b00;
        frame();
        bus.gen_busy = 1'b1;
        tick(1);
        bus.gen_busy = 1'b0;
        tick(1);
        chk("t6_wrap", sent_count, 16'd0);
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
